muldiv_sequencer: RTL and testbench

//  Sequences the shared iterative Mult and Div units on behalf of Control_Unit.

---
 rtl/muldiv_sequencer_pkg.sv | 30 +++
 rtl/muldiv_sequencer_if.sv | 40 ++++
 rtl/muldiv_sequencer_watchdog.sv | 36 +++
 rtl/muldiv_sequencer.sv | 150 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_pkg: shared definitions for the Mult/Div sequencer slice.
//   state_t      - sequencer FSM states
//   UNIT_*       - 2-bit control codes understood by the Mult and Div units
//   DIVSTAT_*    - bit positions inside the Div unit status word
//   route_ctl()  - steers one control code to the selected unit, idles the other
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WRITE,
    ST_DONE,
    ST_EXC
  } state_t;

  localparam logic [1:0] UNIT_IDLE = 2'b00;
  localparam logic [1:0] UNIT_LOAD = 2'b01;
  localparam logic [1:0] UNIT_RUN  = 2'b10;
  localparam logic [1:0] UNIT_CLR  = 2'b11;

  localparam int DIVSTAT_DONE = 0;
  localparam int DIVSTAT_ZERO = 1;

  // Returns {mult_ctl, div_ctl}: the unit not in use always sees UNIT_IDLE.
  function automatic logic [3:0] route_ctl(input logic is_mult, input logic [1:0] code);
    return is_mult ? {code, UNIT_IDLE} : {UNIT_IDLE, code};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response and unit-control bundle of the sequencer.
//   master modport - Control_Unit and the Mult/Div units (drive requests and unit status)
//   slave modport  - muldiv_sequencer (drives unit codes, muxes, Hi/Lo writes, status)
// Signals:
//   start, op_is_mult, src_mem, abort   request side from Control_Unit
//   mult_done, div_status[1:0]          completion status from the units
//   mult_ctl[1:0], div_ctl[1:0]         unit control codes
//   div_or_mult, entry_sel              Hi/Lo source mux and DivMultEntry mux selects
//   write_hi, write_lo                  Hi/Lo write enables
//   busy, done, div0_exc, timeout_exc   status back to Control_Unit
interface muldiv_sequencer_if;
  logic       start;
  logic       op_is_mult;
  logic       src_mem;
  logic       abort;
  logic       mult_done;
  logic [1:0] div_status;
  logic [1:0] mult_ctl;
  logic [1:0] div_ctl;
  logic       div_or_mult;
  logic       entry_sel;
  logic       write_hi;
  logic       write_lo;
  logic       busy;
  logic       done;
  logic       div0_exc;
  logic       timeout_exc;

  modport master (
    output start, op_is_mult, src_mem, abort, mult_done, div_status,
    input  mult_ctl, div_ctl, div_or_mult, entry_sel, write_hi, write_lo,
           busy, done, div0_exc, timeout_exc
  );

  modport slave (
    input  start, op_is_mult, src_mem, abort, mult_done, div_status,
    output mult_ctl, div_ctl, div_or_mult, entry_sel, write_hi, write_lo,
           busy, done, div0_exc, timeout_exc
  );
endinterface

// File: rtl/muldiv_sequencer_watchdog.sv
// muldiv_watchdog: saturating RUN-cycle counter for the sequencer.
//   clock   in  rising-edge clock
//   reset   in  asynchronous active-low reset, count -> 0
//   clear   in  synchronous clear (highest priority)
//   enable  in  count up by one, saturating at MAX_CYCLES-1
//   expired out high while count == MAX_CYCLES-1
// CNT_W must satisfy 2**CNT_W > MAX_CYCLES.
module muldiv_watchdog #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturation keeps the count from wrapping back below LAST.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared iterative Mult and Div units for
// Control_Unit. A request is latched in IDLE, the selected unit is loaded and
// run, and the result is committed to Hi/Lo followed by a done pulse, or an
// exception pulse is raised (divide-by-zero, watchdog timeout).
//   clock  in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    slave modport of muldiv_sequencer_if (requests, unit status,
//          unit codes, mux selects, Hi/Lo writes, status pulses)
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  muldiv_sequencer_if.slave    bus
);

  state_t     state, state_nx;
  logic       op_mult, op_mult_nx;
  logic       src_sel, src_sel_nx;
  logic       exc_div0, exc_div0_nx;

  logic       wd_clear, wd_enable, wd_expired;
  logic       unit_done, div_zero;
  logic [1:0] sel_code;
  logic       write_en, done_p, div0_p, tmo_p;
  logic [3:0] ctl_pair;

  muldiv_watchdog #(
    .MAX_CYCLES(MAX_CYCLES),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Completion only counts from the unit actually in use; a zero divisor is
  // meaningless for a multiply.
  assign unit_done = op_mult ? bus.mult_done : bus.div_status[DIVSTAT_DONE];
  assign div_zero  = !op_mult && bus.div_status[DIVSTAT_ZERO];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_mult  <= 1'b0;
      src_sel  <= 1'b0;
      exc_div0 <= 1'b0;
    end else begin
      state    <= state_nx;
      op_mult  <= op_mult_nx;
      src_sel  <= src_sel_nx;
      exc_div0 <= exc_div0_nx;
    end
  end

  // exc_div0 remembers which exception to report in EXC, so the pulse is
  // decoded from registered state rather than from the unit inputs.
  // An abort forces the clear code during the cycle it is taken.
  always_comb begin
    state_nx    = state;
    op_mult_nx  = op_mult;
    src_sel_nx  = src_sel;
    exc_div0_nx = exc_div0;
    sel_code    = UNIT_IDLE;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    write_en    = 1'b0;
    done_p      = 1'b0;
    div0_p      = 1'b0;
    tmo_p       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          op_mult_nx = bus.op_is_mult;
          src_sel_nx = bus.src_mem;
          state_nx   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sel_code = UNIT_LOAD;
        wd_clear = 1'b1;
        if (bus.abort) begin
          sel_code = UNIT_CLR;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        sel_code  = UNIT_RUN;
        wd_enable = 1'b1;
        if (bus.abort) begin
          sel_code = UNIT_CLR;
          state_nx = ST_IDLE;
        end else if (div_zero) begin
          exc_div0_nx = 1'b1;
          state_nx    = ST_EXC;
        end else if (unit_done) begin
          state_nx = ST_WRITE;
        end else if (wd_expired) begin
          exc_div0_nx = 1'b0;
          state_nx    = ST_EXC;
        end
      end
      ST_WRITE: begin
        sel_code = UNIT_RUN;
        write_en = 1'b1;
        if (bus.abort) begin
          sel_code = UNIT_CLR;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        sel_code = UNIT_CLR;
        done_p   = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_EXC: begin
        sel_code = UNIT_CLR;
        div0_p   = exc_div0;
        tmo_p    = !exc_div0;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign ctl_pair        = route_ctl(op_mult, sel_code);
  assign bus.mult_ctl    = ctl_pair[3:2];
  assign bus.div_ctl     = ctl_pair[1:0];
  assign bus.div_or_mult = op_mult;
  assign bus.entry_sel   = src_sel;
  assign bus.write_hi    = write_en;
  assign bus.write_lo    = write_en;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done_p;
  assign bus.div0_exc    = div0_p;
  assign bus.timeout_exc = tmo_p;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: self-checking bench for muldiv_sequencer.
// Each operation is described by the cycle numbers at which the unit finishes,
// a zero divisor appears, abort and a stray start arrive. The expected outcome
// (kind and RUN cycle of the deciding event) comes from a directed table or,
// for random operations, from a small event-ordering model; the per-cycle
// expected outputs are then derived from that outcome.
module tb_muldiv_sequencer;

  localparam int MAX   = 40;
  localparam int MAX_S = 8;

  typedef enum int {K_DONE, K_DIV0, K_TMO, K_ABORT, K_ABORT_WR} kind_t;

  // d/z: RUN cycle from which done / divisor-zero is asserted (0 = never)
  // c_abort/c_start: cycle after start (1 = LOAD) carrying abort / a stray start
  typedef struct {
    bit    is_mult;
    bit    src;
    int    d;
    int    z;
    int    c_abort;
    int    c_start;
    kind_t kind;
    int    rend;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  muldiv_sequencer_if bus ();
  muldiv_sequencer_if bus8 ();

  muldiv_sequencer #(.MAX_CYCLES(MAX), .CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  muldiv_sequencer #(.MAX_CYCLES(MAX_S), .CNT_W(4)) dut8 (
    .clock(clock),
    .reset(reset),
    .bus  (bus8)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int op_id = 0;
  vec_t tbl[14];

  function automatic logic [11:0] act_vec();
    return {bus.busy, bus.done, bus.div0_exc, bus.timeout_exc, bus.write_hi, bus.write_lo,
            bus.mult_ctl, bus.div_ctl, bus.div_or_mult, bus.entry_sel};
  endfunction

  function automatic int last_busy(input vec_t v);
    case (v.kind)
      K_DONE:     return v.rend + 3;
      K_DIV0:     return v.rend + 2;
      K_TMO:      return v.rend + 2;
      K_ABORT:    return v.rend + 1;
      default:    return v.rend + 2;
    endcase
  endfunction

  // Walks RUN cycles in order and applies abort > div0 > done > timeout.
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    o.kind = K_TMO;
    o.rend = MAX;
    if (v.c_abort == 1) begin
      o.kind = K_ABORT;
      o.rend = 0;
      return o;
    end
    for (int r = 1; r <= MAX; r++) begin
      if (v.c_abort == r + 1) begin
        o.kind = K_ABORT; o.rend = r; return o;
      end
      if (!v.is_mult && v.z != 0 && r >= v.z) begin
        o.kind = K_DIV0; o.rend = r; return o;
      end
      if (v.d != 0 && r >= v.d) begin
        o.kind = (v.c_abort == r + 2) ? K_ABORT_WR : K_DONE;
        o.rend = r;
        return o;
      end
    end
    return o;
  endfunction

  // Expected outputs in cycle c of an operation with a known outcome.
  function automatic void exp_vec(input vec_t v, input int c,
                                  output logic [11:0] e, output logic [11:0] m);
    int last;
    bit busy, is_load, is_run, is_write, is_fin;
    logic [1:0] code;
    last     = last_busy(v);
    busy     = (c >= 1) && (c <= last);
    is_load  = (c == 1);
    is_run   = (c >= 2) && (c <= v.rend + 1);
    is_write = (v.kind == K_DONE || v.kind == K_ABORT_WR) && (c == v.rend + 2);
    is_fin   = (v.kind inside {K_DONE, K_DIV0, K_TMO}) && (c == last);
    code     = is_load ? 2'b01 : (is_run || is_write) ? 2'b10 : is_fin ? 2'b11 : 2'b00;
    e        = '0;
    m        = 12'hFFF;
    e[11]    = busy;
    e[10]    = (v.kind == K_DONE) && is_fin;
    e[9]     = (v.kind == K_DIV0) && is_fin;
    e[8]     = (v.kind == K_TMO) && is_fin;
    e[7]     = is_write;
    e[6]     = is_write;
    e[5:4]   = v.is_mult ? code : 2'b00;
    e[3:2]   = v.is_mult ? 2'b00 : code;
    e[1]     = v.is_mult;
    e[0]     = v.src;
    if (!busy) m[1:0] = 2'b00;
    if ((v.kind == K_ABORT || v.kind == K_ABORT_WR) && c == v.c_abort) m[5:2] = 4'b0000;
  endfunction

  task automatic check_output(input string name, input logic [11:0] act,
                              input logic [11:0] exp, input logic [11:0] mask);
    total++;
    if ((act & mask) !== (exp & mask)) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b (mask %b) [busy done d0 tmo wh wl mctl dctl dom esel]",
               name, act, exp, mask);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Inputs for cycle c; op/src are inverted after start so the latches are exercised.
  task automatic drive_cycle(input vec_t v, input int c, input bit active);
    int r = c - 1;
    bus.start      = active && (c == v.c_start);
    bus.op_is_mult = !v.is_mult;
    bus.src_mem    = !v.src;
    bus.abort      = active && (c == v.c_abort);
    bus.mult_done  = active && v.is_mult && v.d != 0 && r >= 1 && r >= v.d;
    bus.div_status[0] = active && !v.is_mult && v.d != 0 && r >= 1 && r >= v.d;
    bus.div_status[1] = active && v.z != 0 && r >= 1 && r >= v.z;
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the first IDLE cycle after.
  task automatic apply_stimulus(input vec_t v);
    int last;
    logic [11:0] e, m;
    last = last_busy(v);
    op_id++;
    bus.start      = 1'b1;
    bus.op_is_mult = v.is_mult;
    bus.src_mem    = v.src;
    bus.abort      = 1'b0;
    bus.mult_done  = 1'b0;
    bus.div_status = 2'b00;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clock);
      exp_vec(v, c, e, m);
      check_output($sformatf("op%0d_c%0d", op_id, c), act_vec(), e, m);
      drive_cycle(v, c, c <= last);
    end
  endtask

  initial begin
    vec_t v;
    int sel, hit, wr;

    bus.start = 0; bus.op_is_mult = 0; bus.src_mem = 0; bus.abort = 0;
    bus.mult_done = 0; bus.div_status = 0;
    bus8.start = 0; bus8.op_is_mult = 0; bus8.src_mem = 0; bus8.abort = 0;
    bus8.mult_done = 0; bus8.div_status = 0;

    tbl[0]  = '{1, 0, 32, 0,  0, 0, K_DONE,     32};
    tbl[1]  = '{0, 1, 33, 0,  0, 0, K_DONE,     33};
    tbl[2]  = '{0, 0,  0, 2,  0, 0, K_DIV0,      2};
    tbl[3]  = '{1, 0,  0, 0,  0, 0, K_TMO,      40};
    tbl[4]  = '{1, 1, 10, 0, 11, 0, K_ABORT,    10};
    tbl[5]  = '{1, 0,  5, 0,  0, 4, K_DONE,      5};
    tbl[6]  = '{0, 1,  3, 3,  0, 0, K_DIV0,      3};
    tbl[7]  = '{0, 0, 40, 0,  0, 0, K_DONE,     40};
    tbl[8]  = '{1, 0,  7, 0,  9, 0, K_ABORT_WR,  7};
    tbl[9]  = '{0, 1,  4, 0,  1, 0, K_ABORT,     0};
    tbl[10] = '{1, 1,  1, 0,  0, 0, K_DONE,      1};
    tbl[11] = '{1, 0,  3, 0,  6, 0, K_DONE,      3};
    tbl[12] = '{1, 1,  5, 2,  0, 0, K_DONE,      5};
    tbl[13] = '{0, 0,  0, 0,  0, 0, K_TMO,      40};

    repeat (3) @(negedge clock);
    check_output("reset_state", act_vec(), 12'h000, 12'hFFF);
    check_int("reset_small_busy", int'(bus8.busy), 0);
    reset = 1'b1;
    @(negedge clock);
    check_output("idle_after_reset", act_vec(), 12'h000, 12'hFFF);

    $display("[TB] directed table");
    for (int i = 0; i < 14; i++) apply_stimulus(tbl[i]);

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      v.is_mult = 1'($urandom_range(0, 1));
      v.src     = 1'($urandom_range(0, 1));
      sel       = int'($urandom_range(0, 9));
      v.d       = (sel < 5) ? int'($urandom_range(1, 38)) :
                  (sel < 8) ? int'($urandom_range(39, 41)) : 0;
      v.z       = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 40)) : 0;
      v.c_abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : 0;
      v.c_start = 0;
      v         = model(v);
      if ($urandom_range(0, 2) == 0) v.c_start = int'($urandom_range(1, last_busy(v)));
      apply_stimulus(v);
    end

    $display("[TB] reset mid-RUN");
    bus.start = 1'b1; bus.op_is_mult = 1'b1; bus.src_mem = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_output("reset_mid_run", act_vec(), 12'h000, 12'hFFF);
    @(negedge clock);
    reset = 1'b1;
    check_output("idle_after_midrun_reset", act_vec(), 12'h000, 12'hFFF);
    v = '{1, 1, 6, 0, 0, 0, K_DONE, 6};
    apply_stimulus(v);

    $display("[TB] short watchdog instance");
    hit = 0;
    wr  = 0;
    bus8.start = 1'b1;
    bus8.op_is_mult = 1'b1;
    for (int c = 1; c <= 30 && hit == 0; c++) begin
      @(negedge clock);
      bus8.start = 1'b0;
      if (bus8.write_hi || bus8.write_lo) wr++;
      if (bus8.timeout_exc) begin
        hit = c;
        check_int("small_tmo_mult_ctl", int'(bus8.mult_ctl), 3);
      end
    end
    check_int("small_tmo_cycle", hit, MAX_S + 2);
    check_int("small_no_write", wr, 0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
